// File: rtl/alarm_controller_if.sv
// Signal bundle between the alarm controller and the watch datapath:
// button pulses, mode switches, live watch time and the alarm status outputs.
interface alarm_controller_if;
  logic       i_up;
  logic       i_down;
  logic       i_right;
  logic       i_left;
  logic       i_alarm_en;
  logic       i_alarm_set;
  logic [4:0] i_hour;
  logic [5:0] i_min;
  logic [5:0] i_sec;
  logic [4:0] o_alarm_hour;
  logic [5:0] o_alarm_min;
  logic       o_ringing;
  logic       o_buzzer;
  logic [3:0] LED;

  // Drives buttons, switches and watch time; observes the alarm status.
  modport master (
    output i_up, i_down, i_right, i_left, i_alarm_en, i_alarm_set,
    output i_hour, i_min, i_sec,
    input  o_alarm_hour, o_alarm_min, o_ringing, o_buzzer, LED
  );

  // The alarm controller itself.
  modport slave (
    input  i_up, i_down, i_right, i_left, i_alarm_en, i_alarm_set,
    input  i_hour, i_min, i_sec,
    output o_alarm_hour, o_alarm_min, o_ringing, o_buzzer, LED
  );
endinterface

// File: rtl/alarm_controller.sv
// Alarm scheduler: stores an editable alarm time, rings on the rising edge of
// a time match, and sequences snooze, dismiss and auto-dismiss.
module alarm_controller #(
  parameter int TICK_DIV   = 100_000_000,
  parameter int BEEP_DIV   = 50_000,
  parameter int RING_SEC   = 60,
  parameter int SNOOZE_SEC = 300,
  parameter int RST_HOUR   = 7,
  parameter int RST_MIN    = 0
) (
  input logic               clk,
  input logic               reset,
  alarm_controller_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARMED   = 3'd1,
    RINGING = 3'd2,
    SNOOZE  = 3'd3,
    EDIT    = 3'd4
  } state_t;

  typedef enum logic {
    FIELD_MIN  = 1'b0,
    FIELD_HOUR = 1'b1
  } field_t;

  localparam int TICK_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int BEEP_W  = (BEEP_DIV > 1) ? $clog2(BEEP_DIV) : 1;
  localparam int SEC_MAX = (RING_SEC > SNOOZE_SEC) ? RING_SEC : SNOOZE_SEC;
  localparam int SEC_W   = $clog2(SEC_MAX + 1);

  localparam logic [TICK_W-1:0] TICK_LAST   = TICK_W'(TICK_DIV - 1);
  localparam logic [BEEP_W-1:0] BEEP_LAST   = BEEP_W'(BEEP_DIV - 1);
  localparam logic [SEC_W-1:0]  RING_LAST   = SEC_W'(RING_SEC - 1);
  localparam logic [SEC_W-1:0]  SNOOZE_LAST = SEC_W'(SNOOZE_SEC - 1);

  state_t            state;
  state_t            state_next;
  field_t            field;
  logic [4:0]        alarm_hour;
  logic [5:0]        alarm_min;
  logic              match;
  logic              match_d;
  logic              trigger;
  logic [TICK_W-1:0] tick_cnt;
  logic              tick;
  logic [SEC_W-1:0]  sec_cnt;
  logic              ring_done;
  logic              snooze_done;
  logic              timer_restart;
  logic [BEEP_W-1:0] beep_cnt;
  logic              buzzer;
  logic [3:0]        led;

  // Match detection: ring only on the first cycle of a match window.
  assign match   = (bus.i_hour == alarm_hour) && (bus.i_min == alarm_min) &&
                   (bus.i_sec == 6'd0);
  assign trigger = match & ~match_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) match_d <= 1'b0;
    else        match_d <= match;
  end

  assign tick        = (tick_cnt == TICK_LAST);
  assign ring_done   = (state == RINGING) && tick && (sec_cnt == RING_LAST);
  assign snooze_done = (state == SNOOZE)  && tick && (sec_cnt == SNOOZE_LAST);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of block ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // NOTE: state_next gets its default first, so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    state_next = state;
    if (bus.i_alarm_set) begin
      state_next = EDIT;
    end else if (state == EDIT) begin
      state_next = bus.i_alarm_en ? ARMED : IDLE;
    end else if (!bus.i_alarm_en && (state != IDLE)) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (bus.i_alarm_en) state_next = ARMED;
        end
        ARMED: begin
          if (trigger) state_next = RINGING;
        end
        RINGING: begin
          if (bus.i_right)     state_next = ARMED;
          else if (bus.i_left) state_next = SNOOZE;
          else if (ring_done)  state_next = ARMED;
        end
        SNOOZE: begin
          if (snooze_done)      state_next = RINGING;
          else if (bus.i_right) state_next = ARMED;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Timeouts are measured from state entry, so both counters restart there.
  assign timer_restart = (state_next != state) &&
                         ((state_next == RINGING) || (state_next == SNOOZE));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick_cnt <= '0;
      sec_cnt  <= '0;
    end else if (timer_restart) begin
      tick_cnt <= '0;
      sec_cnt  <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
      sec_cnt  <= sec_cnt + SEC_W'(1);
    end else begin
      tick_cnt <= tick_cnt + TICK_W'(1);
    end
  end

  // Buzzer is held low unless the controller stays in RINGING across the edge,
  // which also restarts the tone phase on every entry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      beep_cnt <= '0;
      buzzer   <= 1'b0;
    end else if ((state != RINGING) || (state_next != RINGING)) begin
      beep_cnt <= '0;
      buzzer   <= 1'b0;
    end else if (beep_cnt == BEEP_LAST) begin
      beep_cnt <= '0;
      buzzer   <= ~buzzer;
    end else begin
      beep_cnt <= beep_cnt + BEEP_W'(1);
    end
  end

  // Alarm time editing: one action per cycle, up > down > right > left.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      alarm_hour <= 5'(RST_HOUR);
      alarm_min  <= 6'(RST_MIN);
      field      <= FIELD_MIN;
    end else if (state == EDIT) begin
      if (bus.i_up) begin
        if (field == FIELD_HOUR)
          alarm_hour <= (alarm_hour >= 5'd23) ? 5'd0 : alarm_hour + 5'd1;
        else
          alarm_min  <= (alarm_min >= 6'd59) ? 6'd0 : alarm_min + 6'd1;
      end else if (bus.i_down) begin
        if (field == FIELD_HOUR)
          alarm_hour <= (alarm_hour == 5'd0) ? 5'd23 : alarm_hour - 5'd1;
        else
          alarm_min  <= (alarm_min == 6'd0) ? 6'd59 : alarm_min - 6'd1;
      end else if (bus.i_right || bus.i_left) begin
        field <= (field == FIELD_HOUR) ? FIELD_MIN : FIELD_HOUR;
      end
    end
  end

  always_comb begin
    led = 4'b0000;
    case (state)
      ARMED:   led = 4'b0001;
      RINGING: led = 4'b0010;
      SNOOZE:  led = 4'b0100;
      EDIT:    led = {3'b100, field == FIELD_HOUR};
      default: led = 4'b0000;
    endcase
  end

  assign bus.o_alarm_hour = alarm_hour;
  assign bus.o_alarm_min  = alarm_min;
  assign bus.o_ringing    = (state == RINGING);
  assign bus.o_buzzer     = buzzer;
  assign bus.LED          = led;

endmodule

// File: doc/alarm_controller.md
Name: alarm_controller

Overview:
- Alarm scheduler for the watch datapath. Holds an alarm time (hour/min) that the user edits with the shared debounced buttons.
- Compares the alarm time against the live watch time and sequences ring, snooze and dismiss.
- Drives buzzer and status LEDs.
- Sits beside the watch/stopwatch control unit; consumes the watch counter outputs and the same one-cycle button pulses.

Parameters:
- TICK_DIV, 100_000_000: clk cycles per internal 1 s tick.
- BEEP_DIV, 50_000: clk cycles per o_buzzer half-period.
- RING_SEC, 60: seconds of ringing before auto-dismiss.
- SNOOZE_SEC, 300: snooze duration in seconds.
- RST_HOUR, 7: alarm hour after reset.
- RST_MIN, 0: alarm minute after reset.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous active-low reset.
- i_up  in  1  one-cycle button pulse.
- i_down  in  1  one-cycle button pulse.
- i_right  in  1  one-cycle button pulse; dismiss while ringing.
- i_left  in  1  one-cycle button pulse; snooze while ringing.
- i_alarm_en  in  1  switch: 1 = alarm armed.
- i_alarm_set  in  1  switch: 1 = edit alarm time.
- i_hour  in  5  watch hour, 0-23.
- i_min  in  6  watch minute, 0-59.
- i_sec  in  6  watch second, 0-59.
- o_alarm_hour  out  5  stored alarm hour.
- o_alarm_min  out  6  stored alarm minute.
- o_ringing  out  1  1 in RINGING state.
- o_buzzer  out  1  square wave while ringing, else 0.
- LED  out  4  status.

Behaviour:
- Clocking and reset:
  - One clock; reset is asynchronous and active-low.
  - reset=0 forces state IDLE, edit field MIN, alarm = RST_HOUR:RST_MIN, tick/beep/second counters = 0, match_d = 0.
  - Reset outputs: o_ringing=0, o_buzzer=0, LED=0000.
- States: IDLE, ARMED, RINGING, SNOOZE, EDIT.
- Match detection:
  - match = (i_hour==o_alarm_hour) & (i_min==o_alarm_min) & (i_sec==0); registered into match_d.
  - trigger = match & ~match_d (rising edge only). It fires once per match window.
- Transitions, with priority top to bottom, all registered:
  - i_alarm_set=1 from any state -> EDIT. Silences immediately.
  - EDIT with i_alarm_set=0 -> ARMED if i_alarm_en, else IDLE.
  - i_alarm_en=0 in ARMED/RINGING/SNOOZE -> IDLE.
  - IDLE with i_alarm_en=1 -> ARMED.
  - ARMED with trigger -> RINGING.
  - RINGING with i_right -> ARMED (dismiss).
  - RINGING with i_left -> SNOOZE.
  - RINGING after RING_SEC ticks -> ARMED.
  - SNOOZE after SNOOZE_SEC ticks -> RINGING.
  - SNOOZE with i_right -> ARMED (cancel snooze).
- Tick and second counters:
  - Tick prescaler counts 0..TICK_DIV-1 and emits a 1-cycle tick at TICK_DIV-1.
  - Prescaler and second counter clear on every entry into RINGING or SNOOZE. The first timeout is exactly RING_SEC*TICK_DIV (or SNOOZE_SEC*TICK_DIV) cycles after entry.
- Buzzer:
  - Beep counter runs only in RINGING; o_buzzer toggles when it reaches BEEP_DIV-1.
  - o_buzzer is forced to 0 in every other state, including the cycle the state leaves RINGING.
- EDIT mode:
  - Button priority within a cycle: up > down > right > left; only one action per cycle.
  - i_right or i_left toggles the field between HOUR and MIN.
  - i_up increments the selected field; i_down decrements it.
  - Hour wraps 23<->0; minute wraps 59<->0. Minute wrap does not carry into hour.
  - Edits take effect the next cycle.
- Outside EDIT, i_up and i_down are ignored. Trigger is ignored in IDLE, EDIT and SNOOZE.
- Re-arm: returning to ARMED while match is still 1 does not re-trigger, because match_d is already 1.
- Outputs:
  - o_ringing = (state==RINGING).
  - LED: IDLE 0000; ARMED 0001; RINGING 0010; SNOOZE 0100; EDIT 1000 | {3'b000, field==HOUR}.

Test Plan (TICK_DIV=10, BEEP_DIV=2, RING_SEC=3, SNOOZE_SEC=2):
1. Reset:
   - reset=0 mid-RINGING -> same cycle: o_ringing=0, o_buzzer=0, LED=0000.
   - After release, alarm=07:00.
2. Trigger:
   - en=1, watch steps 06:59:59 -> 07:00:00 -> o_ringing=1 one cycle after the match edge.
   - o_buzzer toggles every 2 cycles.
   - Auto-return to ARMED 30 cycles after entry.
3. Snooze:
   - While RINGING, i_left pulse -> SNOOZE, LED=0100, o_buzzer=0.
   - 20 cycles later -> RINGING again.
   - i_right pulse -> ARMED, LED=0001.
4. Edit wrap:
   - set=1, field MIN, alarm 07:00, i_down -> 07:59.
   - i_right -> field HOUR, LED=1001.
   - i_up x17 -> 00:59.
   - i_up and i_down in the same cycle -> increment only.
5. Precedence:
   - RINGING, then set=1 -> EDIT next cycle, buzzer 0.
   - set=0 with en=0 -> IDLE.
   - A match during EDIT or IDLE never asserts o_ringing.
6. No retrigger:
   - Dismiss with i_right while 07:00:00 is still present -> stays ARMED, o_ringing=0.
